// File: rtl/viterbi_pkg.sv
// Shared types and constants for the 4-state K=3 (7,5) Viterbi add-compare-select datapath.
package viterbi_pkg;

    localparam int NUM_STATES = 4;
    localparam int PM_W       = 6;
    localparam int PM_INIT    = 16;
    localparam int SUM_W      = PM_W + 1;

    typedef logic [1:0]                       state_t;
    typedef logic [PM_W-1:0]                  pm_t;
    typedef logic [SUM_W-1:0]                 sum_t;
    typedef logic [NUM_STATES-1:0][PM_W-1:0]  pm_vec_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } fsm_t;

    localparam pm_t PM_MAX = '1;

    function automatic pm_t sat_pm(sum_t s);
        return (s > sum_t'(PM_MAX)) ? PM_MAX : pm_t'(s);
    endfunction

    // State 0 starts ahead so a fresh frame is anchored to the all-zero encoder state.
    function automatic pm_vec_t pm_reset();
        pm_vec_t v;
        for (int i = 0; i < NUM_STATES; i++) begin
            v[i] = (i == 0) ? '0 : pm_t'(PM_INIT);
        end
        return v;
    endfunction

    // Branch-metric index {c0,c1} for the transition from {b1,b0} on input u.
    function automatic int cw_idx(int u, int b1, int b0);
        return 2 * (u ^ b1 ^ b0) + (u ^ b0);
    endfunction

endpackage

// File: rtl/acs_unit_if.sv
// Beat-level bus between a branch-metric source and the ACS unit, plus debug taps.
interface acs_unit_if;
    import viterbi_pkg::*;

    // valid/ready: a beat transfers on a rising edge where valid && ready; the
    // sender holds its payload stable and valid high until that edge.
    logic [1:0]            bm00, bm01, bm10, bm11;
    logic                  in_valid, in_ready, in_first, in_last;
    logic                  out_valid, out_ready;
    logic [NUM_STATES-1:0] out_dec;
    state_t                out_best;
    logic                  out_last;
    logic                  err;
    fsm_t                  dbg_state;
    pm_vec_t               dbg_pm;

    modport master (
        output bm00, bm01, bm10, bm11, in_valid, in_first, in_last, out_ready,
        input  in_ready, out_valid, out_dec, out_best, out_last, err, dbg_state, dbg_pm
    );

    modport slave (
        input  bm00, bm01, bm10, bm11, in_valid, in_first, in_last, out_ready,
        output in_ready, out_valid, out_dec, out_best, out_last, err, dbg_state, dbg_pm
    );

endinterface

// File: rtl/acs_node.sv
// Compare-select for one trellis state; equal sums keep the b0=0 predecessor.
module acs_node
    import viterbi_pkg::*;
(
    input  sum_t cand0_i,
    input  sum_t cand1_i,
    output sum_t sum_o,
    output logic dec_o
);

    assign dec_o = (cand1_i < cand0_i);
    assign sum_o = dec_o ? cand1_i : cand0_i;

endmodule

// File: rtl/acs_unit.sv
// One trellis step per accepted beat: add-compare-select, normalise metrics,
// and register decisions behind a single-entry output stage.
module acs_unit
    import viterbi_pkg::*;
(
    input logic        clk,
    input logic        rst,
    acs_unit_if.slave  bus
);

    fsm_t                          state_q, state_d;
    pm_vec_t                       pm_q, pm_d, pm_base, pm_norm;
    logic [NUM_STATES-1:0]         dec_q, dec_d, dec_new;
    state_t                        best_q, best_d, best_new;
    logic                          last_q, last_d;
    logic                          out_valid_q, out_valid_d;
    logic                          err_q, err_d;

    logic [NUM_STATES-1:0][1:0]    bm;
    logic [NUM_STATES-1:0][SUM_W-1:0] cand0, cand1, sel;
    sum_t                          min_sum;
    logic                          in_ready, accept, produce;

    assign bm       = {bus.bm11, bus.bm10, bus.bm01, bus.bm00};
    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;
    assign produce  = accept && (bus.in_first || state_q == ST_RUN);
    assign pm_base  = bus.in_first ? pm_reset() : pm_q;

    for (genvar n = 0; n < NUM_STATES; n++) begin : g_node
        localparam int U   = n / 2;
        localparam int B1  = n % 2;
        localparam int P0  = 2 * B1;
        localparam int P1  = 2 * B1 + 1;
        localparam int CW0 = cw_idx(U, B1, 0);
        localparam int CW1 = cw_idx(U, B1, 1);

        assign cand0[n] = sum_t'(pm_base[P0]) + sum_t'(bm[CW0]);
        assign cand1[n] = sum_t'(pm_base[P1]) + sum_t'(bm[CW1]);

        acs_node u_node (
            .cand0_i (cand0[n]),
            .cand1_i (cand1[n]),
            .sum_o   (sel[n]),
            .dec_o   (dec_new[n])
        );
    end

    always_comb begin
        min_sum = sel[0];
        for (int n = 1; n < NUM_STATES; n++) begin
            if (sel[n] < min_sum) min_sum = sel[n];
        end
        pm_norm = '0;
        for (int n = 0; n < NUM_STATES; n++) begin
            pm_norm[n] = sat_pm(sel[n] - min_sum);
        end
        best_new = '0;
        for (int n = 1; n < NUM_STATES; n++) begin
            if (pm_norm[n] < pm_norm[best_new]) best_new = state_t'(n);
        end
    end

    // Beats without in_first while idle are swallowed and only flag the error.
    always_comb begin
        state_d     = state_q;
        pm_d        = pm_q;
        dec_d       = dec_q;
        best_d      = best_q;
        last_d      = last_q;
        err_d       = err_q;
        out_valid_d = out_valid_q && !bus.out_ready;
        if (accept) begin
            if (bus.in_last) begin
                state_d = ST_IDLE;
            end else if (bus.in_first) begin
                state_d = ST_RUN;
            end
            if (!produce) err_d = 1'b1;
        end
        if (produce) begin
            pm_d        = pm_norm;
            dec_d       = dec_new;
            best_d      = best_new;
            last_d      = bus.in_last;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pm_q        <= pm_reset();
            dec_q       <= '0;
            best_q      <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pm_q        <= pm_d;
            dec_q       <= dec_d;
            best_q      <= best_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            err_q       <= err_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_dec   = dec_q;
    assign bus.out_best  = best_q;
    assign bus.out_last  = last_q;
    assign bus.err       = err_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_pm    = pm_q;

endmodule
